tia_horizontal_decode: RTL and testbench

TIA_HORIZONTAL_DECODE -- requirements
Module: tia_horizontal_decode

---
 rtl/tia_horizontal_decode.sv | 59 +++++
 tb/tb_tia_horizontal_decode.sv | 114 +++++++++++
 2 files changed

// File: rtl/tia_horizontal_decode.sv
// tia_horizontal_decode: decodes horizontal LFSR states into sync, blank, burst, centre and step-count outputs
module tia_horizontal_decode #(
  parameter logic [5:0] SHS_PAT  = 6'b111100,
  parameter logic [5:0] RHS_PAT  = 6'b110111,
  parameter logic [5:0] RCB_PAT  = 6'b001111,
  parameter logic [5:0] RHB_PAT  = 6'b011101,
  parameter logic [5:0] LRHB_PAT = 6'b010111,
  parameter logic [5:0] CNT_PAT  = 6'b101100
) (
  input  logic       clk,
  input  logic       rstl,
  input  logic       hstep,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       shb,
  input  logic       hmove,
  output logic       hsync,
  output logic       hblank,
  output logic       cb,
  output logic       hmove_l,
  output logic       cnt,
  output logic [6:0] hcount
);
  logic [5:0] pat;
  logic       dec;
  logic       rhb, lrhb;
  assign pat  = {a, b, c, d, e, f};
  assign dec  = hstep & ~shb;
  assign rhb  = dec & (pat == RHB_PAT) & ~hmove_l;
  assign lrhb = dec & (pat == LRHB_PAT) & hmove_l;
  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      hsync   <= 1'b0;
      hblank  <= 1'b1;
      cb      <= 1'b0;
      hmove_l <= 1'b0;
      cnt     <= 1'b0;
      hcount  <= '0;
    end else begin
      cnt     <= dec & (pat == CNT_PAT);
      hmove_l <= hmove | (hmove_l & ~lrhb);
      if (hstep & shb) begin
        hsync  <= 1'b0;
        hblank <= 1'b1;
        cb     <= 1'b0;
        hcount <= '0;
      end else if (dec) begin
        hcount <= (hcount == 7'd127) ? hcount : hcount + 7'd1;
        hsync  <= (pat == SHS_PAT) ? 1'b1 : (pat == RHS_PAT) ? 1'b0 : hsync;
        cb     <= (pat == RHS_PAT) ? 1'b1 : (pat == RCB_PAT) ? 1'b0 : cb;
        hblank <= (rhb | lrhb) ? 1'b0 : hblank;
      end
    end
  end
endmodule

// File: tb/tb_tia_horizontal_decode.sv
// tb_tia_horizontal_decode: directed and randomized checks against a rule-level model
module tb_tia_horizontal_decode;
  localparam logic [5:0] SHS  = 6'b111100;
  localparam logic [5:0] RHS  = 6'b110111;
  localparam logic [5:0] RCB  = 6'b001111;
  localparam logic [5:0] RHB  = 6'b011101;
  localparam logic [5:0] LRHB = 6'b010111;
  localparam logic [5:0] CNT  = 6'b101100;
  localparam logic [5:0] NONE = 6'b000000;
  logic clk = 0, rstl = 0, hstep = 0, shb = 0, hmove = 0;
  logic a = 0, b = 0, c = 0, d = 0, e = 0, f = 0;
  logic hsync, hblank, cb, hmove_l, cnt;
  logic [6:0] hcount;
  int tests = 0, fails = 0;
  logic m_hsync = 0, m_hblank = 1, m_cb = 0, m_hl = 0, m_cnt = 0;
  int m_hc = 0;
  logic [5:0] pats [7] = '{SHS, RHS, RCB, RHB, LRHB, CNT, NONE};

  tia_horizontal_decode dut (
    .clk(clk), .rstl(rstl), .hstep(hstep),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .shb(shb), .hmove(hmove),
    .hsync(hsync), .hblank(hblank), .cb(cb), .hmove_l(hmove_l), .cnt(cnt), .hcount(hcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hsync"}, 7'(hsync), 7'(m_hsync));
    chk({tag, ".hblank"}, 7'(hblank), 7'(m_hblank));
    chk({tag, ".cb"}, 7'(cb), 7'(m_cb));
    chk({tag, ".hmove_l"}, 7'(hmove_l), 7'(m_hl));
    chk({tag, ".cnt"}, 7'(cnt), 7'(m_cnt));
    chk({tag, ".hcount"}, hcount, 7'(m_hc));
  endtask

  task automatic model_reset();
    m_hsync = 0; m_hblank = 1; m_cb = 0; m_hl = 0; m_cnt = 0; m_hc = 0;
  endtask

  task automatic cyc(input string tag, input logic hs, input logic [5:0] p, input logic sb, input logic hm);
    logic nl;
    hstep = hs; {a, b, c, d, e, f} = p; shb = sb; hmove = hm;
    nl = m_hl;
    m_cnt = hs && !sb && p == CNT;
    if (hs && sb) begin
      m_hblank = 1; m_hc = 0; m_cb = 0; m_hsync = 0;
    end else if (hs) begin
      m_hc = (m_hc >= 127) ? 127 : m_hc + 1;
      if (p == SHS) m_hsync = 1;
      if (p == RHS) begin m_hsync = 0; m_cb = 1; end
      if (p == RCB) m_cb = 0;
      if (p == RHB && !m_hl) m_hblank = 0;
      if (p == LRHB && m_hl) begin m_hblank = 0; nl = 0; end
    end
    m_hl = nl | hm;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    @(posedge clk); #1;
    check_all("reset");
    rstl = 1;
    cyc("r36_shb", 1, NONE, 1, 0);
    cyc("r36_shs", 1, SHS, 0, 0);
    cyc("r36_rhs", 1, RHS, 0, 0);
    cyc("r36_rcb", 1, RCB, 0, 0);
    cyc("r36_rhb", 1, RHB, 0, 0);
    chk("r36_hcount4", hcount, 7'd4);
    chk("r36_unblank", 7'(hblank), 7'd0);
    cyc("r37_shb", 1, NONE, 1, 0);
    cyc("r37_hmove", 0, NONE, 0, 1);
    cyc("r37_rhb", 1, RHB, 0, 0);
    chk("r37_blank_held", 7'(hblank), 7'd1);
    cyc("r37_lrhb", 1, LRHB, 0, 0);
    chk("r37_hl_clear", 7'(hmove_l), 7'd0);
    cyc("r38_shb_rhb", 1, RHB, 1, 0);
    chk("r38_hcount0", hcount, 7'd0);
    cyc("r38_hmove", 1, NONE, 0, 1);
    cyc("r38_lrhb_set", 1, LRHB, 0, 1);
    chk("r38_hl_wins", 7'(hmove_l), 7'd1);
    for (int i = 0; i < 130; i++) cyc("r39_run", 1, NONE, 0, 0);
    chk("r39_sat", hcount, 7'd127);
    cyc("r39_cnt", 1, CNT, 0, 0);
    chk("r39_cnt_hi", 7'(cnt), 7'd1);
    cyc("r39_idle", 0, CNT, 0, 0);
    cyc("r39_noshs", 0, SHS, 0, 0);
    chk("r39_hsync_hold", 7'(hsync), 7'd0);
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : pats[$urandom_range(0, 6)],
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
    cyc("r40_shb", 1, NONE, 1, 0);
    cyc("r40_rhs", 1, RHS, 0, 1);
    cyc("r40_shs", 1, SHS, 0, 0);
    chk("r40_pre_hsync", 7'(hsync), 7'd1);
    #2 rstl = 0;
    #1 model_reset();
    check_all("r40_async");
    #1 rstl = 1;
    cyc("r40_after", 1, SHS, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
